// File: rtl/fnd_bin_scan.sv
// rtl/fnd_bin_scan.sv - 14-bit binary to 4-digit BCD converter with multiplexed 7-segment scan.
// Optional leading-zero blanking via FND_LEADING_ZERO_BLANK_EN.
module fnd_bin_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [13:0] value,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  output logic        busy,
  output logic [7:0]  seg_n,
  output logic [3:0]  com_n
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_TERM = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [13:0]   bin_q;
  logic [15:0]   bcd_q;
  logic [15:0]   bcd_adj;
  logic [3:0]    step_q;
  logic [15:0]   disp_q;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic [3:0]    digit_sel;
  logic [3:0]    blank;
  logic [6:0]    seg_dec;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (step_q == 4'd13) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction of each BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      disp_q <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_q  <= (value > 14'd9999) ? 14'd9999 : value;
          bcd_q  <= '0;
          step_q <= '0;
        end
        CONV: begin
          bcd_q  <= {bcd_adj[14:0], bin_q[13]};
          bin_q  <= {bin_q[12:0], 1'b0};
          step_q <= step_q + 4'd1;
        end
        DONE:    disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

  assign idx_next = (scan_cnt == SCAN_TERM) ? idx + 2'd1 : idx;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= (scan_cnt == SCAN_TERM) ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank    = '0;
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
  end
`else
  assign blank = 4'b0000;
`endif

  assign digit_sel = disp_q[{idx_next, 2'b00} +: 4];
  assign seg_dec   = blank[idx_next] ? 7'h7F : decode(digit_sel);

  // Outputs follow idx_next so com_n and seg_n always agree with the current index.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      com_n <= 4'b1110;
      seg_n <= 8'hC0;
    end else begin
      com_n <= ~(4'b0001 << idx_next);
      seg_n <= {~dp_mask[idx_next], seg_dec};
    end
  end

endmodule

// File: tb/tb_fnd_bin_scan.sv
// tb/tb_fnd_bin_scan.sv - scoreboard bench for fnd_bin_scan with SCAN_DIV=4.
module tb_fnd_bin_scan;

  logic        clk;
  logic        reset_p;
  logic [13:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        busy;
  logic [7:0]  seg_n;
  logic [3:0]  com_n;

  int vectors = 0;
  int miscompares = 0;
  int exp_done = 0;
  int mon_done = 0;

  typedef struct {
    int         val;
    logic [3:0] dp;
  } exp_t;
  exp_t sb[$];

  fnd_bin_scan #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .value   (value),
    .load    (load),
    .dp_mask (dp_mask),
    .busy    (busy),
    .seg_n   (seg_n),
    .com_n   (com_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input int val, input int k, input logic [3:0] dp);
    logic [7:0] tbl [10];
    int v, d, p;
    logic [7:0] s;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    v = (val > 9999) ? 9999 : val;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    d = (v / p) % 10;
    s = tbl[d];
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (k > 0 && v < p) s = 8'hFF;
`endif
    s[7] = ~dp[k];
    return s;
  endfunction

  task automatic check_scan(input int val, input logic [3:0] dp);
    logic [3:0] want;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      int n;
      want = ~(4'b0001 << k);
      n = 0;
      while (com_n !== want && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("com_n_digit%0d", k), com_n, want);
      chk($sformatf("seg_v%0d_d%0d", val, k), seg_n, model_seg(val, k, dp));
    end
  endtask

  // Monitor: on every completed conversion, verify busy length and pop the expected display.
  initial begin
    int  busy_cnt;
    logic prev;
    exp_t e;
    busy_cnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_p) begin
        busy_cnt = 0;
        prev = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (prev && !busy) begin
          chk("busy_len", busy_cnt, 15);
          chk("pending", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_scan(e.val, e.dp);
          end
          mon_done++;
          busy_cnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic do_load(input int val, input logic [3:0] dp, input bit accepted);
    exp_t e;
    @(negedge clk);
    value   = 14'(val);
    dp_mask = dp;
    load    = 1'b1;
    if (accepted) begin
      e.val = val;
      e.dp  = dp;
      sb.push_back(e);
      exp_done++;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (mon_done < exp_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", (mon_done >= exp_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    value   = '0;
    load    = 1'b0;
    dp_mask = 4'b0000;
    reset_p = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_com_n", com_n, 4'b1110);
    chk("rst_seg_n", seg_n, 8'hC0);
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] want;
      @(negedge clk);
      want = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk("rot_com_n", com_n, want);
      chk("rot_seg_n", seg_n, 8'hC0);
    end

    do_load(1234, 4'b0000, 1);
    wait_done();
    do_load(12000, 4'b0000, 1);
    wait_done();

    do_load(1234, 4'b0000, 1);
    repeat (3) @(negedge clk);
    do_load(5678, 4'b0000, 0);
    wait_done();
    do_load(5678, 4'b0000, 1);
    wait_done();

    do_load(7, 4'b0100, 1);
    wait_done();

    // load presented in the DONE cycle must be dropped
    do_load(42, 4'b0011, 1);
    repeat (14) @(negedge clk);
    value = 14'd9;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    @(negedge clk);
    chk("load_on_fall", busy, 0);
    wait_done();

    for (int r = 0; r < 12; r++) begin
      do_load($urandom_range(16383, 0), 4'($urandom_range(15, 0)), 1);
      wait_done();
    end
    do_load(9999, 4'b1111, 1);
    wait_done();
    do_load(0, 4'b0000, 1);
    wait_done();

    // abort during conversion
    do_load(4321, 4'b0000, 0);
    repeat (7) @(negedge clk);
    reset_p = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_com_n", com_n, 4'b1110);
    chk("abort_seg_n", seg_n, 8'hC0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    check_scan(0, 4'b0000);
    do_load(4321, 4'b0000, 1);
    wait_done();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
